// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory control bus bit positions, MEM-stage FSM
// states and access-size encoding.
package mips_pkg;

  // Bit positions inside the 9-bit memory control bus from decode
  localparam int SB       = 8;
  localparam int SH       = 7;
  localparam int LB       = 6;
  localparam int LH       = 5;
  localparam int UNS      = 4;
  localparam int BNEQ     = 3;
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

endpackage

// File: rtl/mem_load_extend.sv
// Load data path: picks the addressed byte/halfword out of the memory word
// and sign- or zero-extends it to the full data width.
module mem_load_extend
  import mips_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] i_word,
  input  logic [1:0]         i_addr_lo,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  output logic [NB_DATA-1:0] o_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension; halfwords are already 2-byte aligned
  always_comb begin
    byte_sel = i_word[{i_addr_lo, 3'b000} +: 8];
    half_sel = i_word[{i_addr_lo[1], 4'b0000} +: 16];
    o_data   = i_word;
    if (i_size == SZ_BYTE)
      o_data = {{(NB_DATA-8){~i_unsigned & byte_sel[7]}}, byte_sel};
    else if (i_size == SZ_HALF)
      o_data = {{(NB_DATA-16){~i_unsigned & half_sel[15]}}, half_sel};
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: turns decoded loads/stores into a
// req/ack transaction, stalls the pipe while it is outstanding, and returns
// extended load data or a timeout/misalignment pulse.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int NB_ADDR   = 32,
  parameter int NB_CTRL_M = 9,
  parameter int MAX_WAIT  = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [NB_CTRL_M-1:0] i_ctrl_mem_bus,
  input  logic [NB_ADDR-1:0]   i_addr,
  input  logic [NB_DATA-1:0]   i_wdata,
  output logic                 o_stall,
  output logic [NB_DATA-1:0]   o_rdata,
  output logic                 o_rdata_valid,
  output logic                 o_misaligned,
  output logic                 o_timeout,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [NB_ADDR-1:0]   o_mem_addr,
  output logic [3:0]           o_mem_be,
  output logic [NB_DATA-1:0]   o_mem_wdata,
  input  logic                 i_mem_ack,
  input  logic [NB_DATA-1:0]   i_mem_rdata
);

  localparam int                NB_CNT  = $clog2(MAX_WAIT + 1);
  localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(MAX_WAIT);

  state_e              state_q;
  logic [NB_CNT-1:0]   cnt_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [1:0]          alo_q;
  logic                req_q, we_q, rvalid_q, tmo_q;
  logic [NB_ADDR-1:0]  maddr_q;
  logic [3:0]          be_q;
  logic [NB_DATA-1:0]  wdata_q, rdata_q, ext_rdata;

  logic                op_d, we_d, aligned_d, start_d;
  logic [1:0]          size_d;
  logic [3:0]          be_d;
  logic [NB_DATA-1:0]  wdata_d;

  // Branch bits travel on the same bus but belong to another stage
  logic unused_branch_bits;
  assign unused_branch_bits = ^{i_ctrl_mem_bus[BNEQ], i_ctrl_mem_bus[BRANCH]};

  // Decode the control bus: op, direction, size, alignment and store lanes
  always_comb begin
    op_d = i_valid & (i_ctrl_mem_bus[MEMREAD] | i_ctrl_mem_bus[MEMWRITE]);
    we_d = i_ctrl_mem_bus[MEMWRITE];
    size_d = SZ_WORD;
    if (we_d) begin
      if (i_ctrl_mem_bus[SB])      size_d = SZ_BYTE;
      else if (i_ctrl_mem_bus[SH]) size_d = SZ_HALF;
    end else begin
      if (i_ctrl_mem_bus[LB])      size_d = SZ_BYTE;
      else if (i_ctrl_mem_bus[LH]) size_d = SZ_HALF;
    end
    aligned_d = 1'b1;
    be_d      = 4'b1111;
    wdata_d   = i_wdata;
    case (size_d)
      SZ_BYTE: begin
        be_d    = 4'b0001 << i_addr[1:0];
        wdata_d = {(NB_DATA/8){i_wdata[7:0]}};
      end
      SZ_HALF: begin
        aligned_d = ~i_addr[0];
        be_d      = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d   = {(NB_DATA/16){i_wdata[15:0]}};
      end
      default: aligned_d = (i_addr[1:0] == 2'b00);
    endcase
    start_d = (state_q == S_IDLE) & op_d & aligned_d;
  end

  mem_load_extend #(.NB_DATA(NB_DATA)) u_load_extend (
    .i_word     (i_mem_rdata),
    .i_addr_lo  (alo_q),
    .i_size     (size_q),
    .i_unsigned (uns_q),
    .o_data     (ext_rdata)
  );

  // Transaction FSM with its timeout counter and registered memory-side outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      alo_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      tmo_q    <= 1'b0;
      case (state_q)
        S_IDLE: if (start_d) begin
          state_q <= S_ACCESS;
          cnt_q   <= '0;
          req_q   <= 1'b1;
          we_q    <= we_d;
          maddr_q <= {i_addr[NB_ADDR-1:2], 2'b00};
          be_q    <= be_d;
          wdata_q <= wdata_d;
          size_q  <= size_d;
          uns_q   <= i_ctrl_mem_bus[UNS];
          alo_q   <= i_addr[1:0];
        end
        S_ACCESS: begin
          // An ack in the final wait cycle still completes the access
          if (i_mem_ack) begin
            req_q   <= 1'b0;
            state_q <= S_RESP;
            if (!we_q) begin
              rdata_q  <= ext_rdata;
              rvalid_q <= 1'b1;
            end
          end else if (cnt_q == CNT_MAX) begin
            req_q   <= 1'b0;
            state_q <= S_RESP;
            tmo_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // Single response cycle; the instruction still held upstream is not reissued
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_stall       = start_d | (state_q == S_ACCESS);
  assign o_misaligned  = (state_q == S_IDLE) & op_d & ~aligned_d;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rvalid_q;
  assign o_timeout     = tmo_q;
  assign o_mem_req     = req_q;
  assign o_mem_we      = we_q;
  assign o_mem_addr    = maddr_q;
  assign o_mem_be      = be_q;
  assign o_mem_wdata   = wdata_q;

endmodule
